// File: rtl/fast_square_sweep_ctrl.sv
// Sweep controller for fast_square_rx: steps the synthesizer, waits for PLL lock,
// settles, then opens one RX record window per step, with sticky lock-fault flags.
module fast_square_sweep_ctrl #(
  parameter int FR_BASE      = 64,
  parameter int CNT_W        = 16,
  parameter int STEP_W       = 8,
  parameter int SETTLE_TICKS = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int PULSE_TICKS  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              serial_strobe,
  input  logic [6:0]        serial_addr,
  input  logic [31:0]       serial_data,
  input  logic              pll_locked,
  output logic              freq_step_reset_out,
  output logic              freq_step_out,
  output logic              rx_reset,
  output logic              rx_next,
  output logic              rx_record,
  output logic [STEP_W-1:0] step_index,
  output logic              busy,
  output logic              sweep_done,
  output logic              lock_fail,
  output logic              lock_drop
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_LOCK, SETTLE, RECORD, ADVANCE, STEP
  } state_t;

  localparam logic [6:0]       ADDR_CFG0    = 7'(FR_BASE);
  localparam logic [6:0]       ADDR_CFG1    = 7'(FR_BASE + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_TICKS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // Lock seen in the first two WAIT_LOCK cycles may be stale pre-step lock
  // still draining out of the synchronizer, so it is not trusted.
  localparam logic [CNT_W-1:0] LOCK_BLANK   = CNT_W'(2);
  localparam logic [CNT_W-1:0] RECORD_RESET = CNT_W'(15000);

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_index_q, step_index_d;
  logic [CNT_W-1:0]  record_ticks_q, record_ticks_d;
  logic [STEP_W-1:0] num_steps_q, num_steps_d;
  logic              continuous_q, continuous_d;
  logic              enable_q, enable_d;
  logic [CNT_W-1:0]  rec_sh_q, rec_sh_d;
  logic [STEP_W-1:0] steps_sh_q, steps_sh_d;
  logic              lock_meta_q, lock_sync_q;
  logic              freq_step_reset_q, freq_step_reset_d;
  logic              freq_step_q, freq_step_d;
  logic              rx_reset_q, rx_reset_d;
  logic              rx_next_q, rx_next_d;
  logic              rx_record_q, rx_record_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;
  logic              lock_fail_q, lock_fail_d;
  logic              lock_drop_q, lock_drop_d;

  logic              cfg0_wr, cfg1_wr, enable_wr, flag_clr;
  logic              fail_set, drop_set, single_shot_end;
  logic [CNT_W-1:0]  rec_last;
  logic [STEP_W-1:0] steps_last;
  logic              unused_data_bits;

  assign unused_data_bits = ^serial_data[31:19];

  assign cfg0_wr    = serial_strobe && (serial_addr == ADDR_CFG0);
  assign cfg1_wr    = serial_strobe && (serial_addr == ADDR_CFG1);
  assign rec_last   = (rec_sh_q == '0) ? '0 : rec_sh_q - CNT_W'(1);
  assign steps_last = (steps_sh_q == '0) ? '0 : steps_sh_q - STEP_W'(1);

  always_comb begin
    record_ticks_d = record_ticks_q;
    num_steps_d    = num_steps_q;
    continuous_d   = continuous_q;
    enable_wr      = enable_q;
    flag_clr       = 1'b0;
    if (cfg0_wr) begin
      record_ticks_d = serial_data[CNT_W-1:0];
    end
    if (cfg1_wr) begin
      num_steps_d  = serial_data[STEP_W-1:0];
      continuous_d = serial_data[16];
      enable_wr    = serial_data[17];
      flag_clr     = serial_data[18];
    end
  end

  always_comb begin
    state_d         = state_q;
    step_index_d    = step_index_q;
    rec_sh_d        = rec_sh_q;
    steps_sh_d      = steps_sh_q;
    fail_set        = 1'b0;
    drop_set        = 1'b0;
    single_shot_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_q) state_d = START;
      end
      START: begin
        if (cnt_q == PULSE_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_sync_q && (cnt_q >= LOCK_BLANK)) begin
          state_d = SETTLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fail_set = 1'b1;
          state_d  = ADVANCE;
        end
      end
      SETTLE: begin
        if (!lock_sync_q) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = RECORD;
        end
      end
      RECORD: begin
        if (!lock_sync_q) drop_set = 1'b1;
        if (cnt_q == rec_last) state_d = ADVANCE;
      end
      ADVANCE: begin
        if (step_index_q == steps_last) begin
          if (continuous_q) begin
            state_d = START;
          end else begin
            single_shot_end = 1'b1;
            state_d         = IDLE;
          end
        end else begin
          step_index_d = step_index_q + STEP_W'(1);
          state_d      = STEP;
        end
      end
      STEP: begin
        if (cnt_q == PULSE_LAST) state_d = WAIT_LOCK;
      end
      default: state_d = IDLE;
    endcase

    // A disabling write aborts the sweep on the very next edge.
    if (!enable_wr) begin
      state_d      = IDLE;
      step_index_d = step_index_q;
    end

    if ((state_d == START) && (state_q != START)) begin
      step_index_d = '0;
      rec_sh_d     = record_ticks_q;
      steps_sh_d   = num_steps_q;
    end
  end

  always_comb begin
    enable_d          = cfg1_wr ? serial_data[17] : (enable_q && !single_shot_end);
    cnt_d             = ((state_d == IDLE) || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);
    rx_reset_d        = (state_d == START);
    freq_step_reset_d = (state_d == START);
    freq_step_d       = (state_d == STEP);
    rx_record_d       = (state_d == RECORD);
    rx_next_d         = (state_d == ADVANCE);
    sweep_done_d      = (state_d == ADVANCE) && (step_index_q == steps_last);
    busy_d            = (state_d != IDLE);
    lock_fail_d       = fail_set || (lock_fail_q && !flag_clr);
    lock_drop_d       = drop_set || (lock_drop_q && !flag_clr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      step_index_q      <= '0;
      record_ticks_q    <= RECORD_RESET;
      num_steps_q       <= STEP_W'(1);
      continuous_q      <= 1'b0;
      enable_q          <= 1'b0;
      rec_sh_q          <= '0;
      steps_sh_q        <= '0;
      lock_meta_q       <= 1'b0;
      lock_sync_q       <= 1'b0;
      freq_step_reset_q <= 1'b0;
      freq_step_q       <= 1'b0;
      rx_reset_q        <= 1'b0;
      rx_next_q         <= 1'b0;
      rx_record_q       <= 1'b0;
      busy_q            <= 1'b0;
      sweep_done_q      <= 1'b0;
      lock_fail_q       <= 1'b0;
      lock_drop_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      step_index_q      <= step_index_d;
      record_ticks_q    <= record_ticks_d;
      num_steps_q       <= num_steps_d;
      continuous_q      <= continuous_d;
      enable_q          <= enable_d;
      rec_sh_q          <= rec_sh_d;
      steps_sh_q        <= steps_sh_d;
      lock_meta_q       <= pll_locked;
      lock_sync_q       <= lock_meta_q;
      freq_step_reset_q <= freq_step_reset_d;
      freq_step_q       <= freq_step_d;
      rx_reset_q        <= rx_reset_d;
      rx_next_q         <= rx_next_d;
      rx_record_q       <= rx_record_d;
      busy_q            <= busy_d;
      sweep_done_q      <= sweep_done_d;
      lock_fail_q       <= lock_fail_d;
      lock_drop_q       <= lock_drop_d;
    end
  end

  assign freq_step_reset_out = freq_step_reset_q;
  assign freq_step_out       = freq_step_q;
  assign rx_reset            = rx_reset_q;
  assign rx_next             = rx_next_q;
  assign rx_record           = rx_record_q;
  assign step_index          = step_index_q;
  assign busy                = busy_q;
  assign sweep_done          = sweep_done_q;
  assign lock_fail           = lock_fail_q;
  assign lock_drop           = lock_drop_q;

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Bench for fast_square_sweep_ctrl: table vectors, randomized sweeps against a
// cycle-count model, and hand-written lock/abort/reset sequences.
module tb_fast_square_sweep_ctrl;

  localparam int PULSE   = 4;
  localparam int SETTLE  = 64;
  localparam int TIMEOUT = 4096;
  localparam logic [6:0] CFG0 = 7'd64;
  localparam logic [6:0] CFG1 = 7'd65;
  localparam int EN   = 1 << 17;
  localparam int CONT = 1 << 16;
  localparam int CLR  = 1 << 18;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        serial_strobe = 1'b0;
  logic [6:0]  serial_addr = '0;
  logic [31:0] serial_data = '0;
  logic        pll_locked = 1'b1;
  logic        freq_step_reset_out, freq_step_out, rx_reset, rx_next, rx_record;
  logic [7:0]  step_index;
  logic        busy, sweep_done, lock_fail, lock_drop;

  fast_square_sweep_ctrl dut (
    .clock(clock), .reset_n(reset_n), .serial_strobe(serial_strobe),
    .serial_addr(serial_addr), .serial_data(serial_data), .pll_locked(pll_locked),
    .freq_step_reset_out(freq_step_reset_out), .freq_step_out(freq_step_out),
    .rx_reset(rx_reset), .rx_next(rx_next), .rx_record(rx_record),
    .step_index(step_index), .busy(busy), .sweep_done(sweep_done),
    .lock_fail(lock_fail), .lock_drop(lock_drop)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Observed activity, gathered by the monitor and read from a per-test base.
  int win_q[$];
  int stp_q[$];
  int nxt_q[$];
  int rst_rises = 0;
  int done_cnt = 0;
  int rec_run = 0;
  int stp_run = 0;
  bit prev_rst = 1'b0;
  int win_base, stp_base, nxt_base, rst_base, done_base;

  always @(negedge clock) begin
    if (!reset_n) begin
      rec_run  = 0;
      stp_run  = 0;
      prev_rst = 1'b0;
    end else begin
      if (rx_record) rec_run++;
      else if (rec_run > 0) begin win_q.push_back(rec_run); rec_run = 0; end
      if (freq_step_out) stp_run++;
      else if (stp_run > 0) begin stp_q.push_back(stp_run); stp_run = 0; end
      if (freq_step_reset_out && !prev_rst) rst_rises++;
      prev_rst = freq_step_reset_out;
      if (rx_next) nxt_q.push_back(int'(step_index));
      if (sweep_done) done_cnt++;
    end
  end

  typedef struct {
    int rec;
    int steps;
    int exp_done;
    int exp_win;
    int exp_windows;
    int exp_pulses;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic writeCfg(input logic [6:0] a, input int d);
    serial_strobe = 1'b1;
    serial_addr   = a;
    serial_data   = d;
    @(posedge clock); #1;
    serial_strobe = 1'b0;
    serial_addr   = '0;
    serial_data   = '0;
  endtask

  task automatic markBase();
    win_base  = win_q.size();
    stp_base  = stp_q.size();
    nxt_base  = nxt_q.size();
    rst_base  = rst_rises;
    done_base = done_cnt;
  endtask

  function automatic bit sig(input int w);
    case (w)
      0:       return rx_record;
      1:       return freq_step_out;
      default: return busy;
    endcase
  endfunction

  task automatic waitSig(input int w, input bit val, input int bound, input string name);
    int k = 0;
    while (sig(w) !== val && k < bound) begin @(posedge clock); #1; k++; end
    if (sig(w) !== val) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic waitDone(input int bound, output int n);
    n = 0;
    while (!sweep_done && n < bound) begin @(posedge clock); #1; n++; end
    if (!sweep_done) begin
      checkOutput("sweep_done_timeout", 0, 1);
      n = -1;
    end
  endtask

  task automatic applyStimulus(input int rec, input int steps, output int done_at);
    markBase();
    writeCfg(CFG0, rec);
    writeCfg(CFG1, EN | steps);
    waitDone(70000, done_at);
  endtask

  // Call right on the sweep_done sample; exp_done < 0 skips the latency check.
  task automatic checkSweep(input string tag, input int done_at, input int exp_done,
                            input int exp_win, input int exp_windows, input int exp_pulses);
    int bad;
    if (exp_done >= 0) checkOutput({tag, "_done_cycle"}, done_at, exp_done);
    checkOutput({tag, "_next_with_done"}, int'(rx_next), 1);
    waitCycles(2);
    checkOutput({tag, "_busy_after"}, int'(busy), 0);
    checkOutput({tag, "_windows"}, win_q.size() - win_base, exp_windows);
    bad = 0;
    for (int i = win_base; i < win_q.size(); i++) if (win_q[i] != exp_win) bad++;
    checkOutput({tag, "_bad_window_len"}, bad, 0);
    checkOutput({tag, "_step_pulses"}, stp_q.size() - stp_base, exp_pulses);
    bad = 0;
    for (int i = stp_base; i < stp_q.size(); i++) if (stp_q[i] != PULSE) bad++;
    checkOutput({tag, "_bad_pulse_width"}, bad, 0);
    checkOutput({tag, "_next_count"}, nxt_q.size() - nxt_base, exp_pulses + 1);
    bad = 0;
    for (int i = nxt_base; i < nxt_q.size(); i++) if (nxt_q[i] != i - nxt_base) bad++;
    checkOutput({tag, "_bad_step_index"}, bad, 0);
    checkOutput({tag, "_done_pulses"}, done_cnt - done_base, 1);
  endtask

  // Model: each locked step costs pulse + 3 + settle + window + 1 cycles,
  // counted from the edge that captures the enabling write.
  function automatic int modelDone(input int rec, input int steps);
    int er = (rec == 0) ? 1 : rec;
    int es = (steps == 0) ? 1 : steps;
    return es * (PULSE + 3 + SETTLE + er + 1);
  endfunction

  initial begin
    int n, n2, rec, steps, idx, done_snap;
    vecs[0] = '{rec: 100, steps: 3, exp_done: 516, exp_win: 100, exp_windows: 3, exp_pulses: 2};
    vecs[1] = '{rec: 0,   steps: 0, exp_done: 73,  exp_win: 1,   exp_windows: 1, exp_pulses: 0};
    vecs[2] = '{rec: 5,   steps: 2, exp_done: 154, exp_win: 5,   exp_windows: 2, exp_pulses: 1};
    vecs[3] = '{rec: 1,   steps: 4, exp_done: 292, exp_win: 1,   exp_windows: 4, exp_pulses: 3};

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_rx_record", int'(rx_record), 0);
    checkOutput("rst_rx_reset", int'(rx_reset), 0);
    checkOutput("rst_step_reset", int'(freq_step_reset_out), 0);
    checkOutput("rst_step", int'(freq_step_out), 0);
    checkOutput("rst_step_index", int'(step_index), 0);
    checkOutput("rst_lock_fail", int'(lock_fail), 0);
    checkOutput("rst_sweep_done", int'(sweep_done), 0);
    reset_n = 1'b1;
    waitCycles(5);
    checkOutput("idle_after_reset", int'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].rec, vecs[i].steps, n);
      checkSweep($sformatf("vec%0d", i), n, vecs[i].exp_done, vecs[i].exp_win,
                 vecs[i].exp_windows, vecs[i].exp_pulses);
      waitCycles(3);
    end

    for (int i = 0; i < 6; i++) begin
      rec   = int'($urandom_range(0, 30));
      steps = int'($urandom_range(0, 4));
      applyStimulus(rec, steps, n);
      checkSweep($sformatf("rand%0d", i), n, modelDone(rec, steps),
                 (rec == 0) ? 1 : rec, (steps == 0) ? 1 : steps, (steps == 0) ? 0 : steps - 1);
      waitCycles(3);
    end

    // Lock held off for step 1 of 3: that step times out and skips its window.
    markBase();
    writeCfg(CFG0, 100);
    writeCfg(CFG1, EN | 3);
    waitSig(1, 1'b1, 1000, "lf_step_rise");
    pll_locked = 1'b0;
    checkOutput("lf_step_index", int'(step_index), 1);
    waitSig(1, 1'b0, 10, "lf_step_fall");
    n = 0;
    while (!lock_fail && n < 5000) begin @(posedge clock); #1; n++; end
    checkOutput("lf_timeout_cycles", n, TIMEOUT);
    checkOutput("lf_rx_next_at_timeout", int'(rx_next), 1);
    pll_locked = 1'b1;
    waitDone(2000, n2);
    waitCycles(2);
    checkOutput("lf_windows", win_q.size() - win_base, 2);
    checkOutput("lf_next_count", nxt_q.size() - nxt_base, 3);
    checkOutput("lf_done_pulses", done_cnt - done_base, 1);
    checkOutput("lf_flag", int'(lock_fail), 1);
    checkOutput("lf_no_drop", int'(lock_drop), 0);
    checkOutput("lf_busy", int'(busy), 0);

    // Lock lost for 10 cycles mid-window: flag set, window length unchanged.
    markBase();
    writeCfg(CFG1, EN | 1);
    waitSig(0, 1'b1, 500, "ld_record");
    waitCycles(30);
    pll_locked = 1'b0;
    waitCycles(10);
    pll_locked = 1'b1;
    waitDone(500, n);
    waitCycles(2);
    checkOutput("ld_flag", int'(lock_drop), 1);
    checkOutput("ld_windows", win_q.size() - win_base, 1);
    checkOutput("ld_window_len", (win_q.size() > win_base) ? win_q[win_base] : -1, 100);
    writeCfg(CFG1, CLR | 1);
    checkOutput("clr_lock_fail", int'(lock_fail), 0);
    checkOutput("clr_lock_drop", int'(lock_drop), 0);

    // Continuous mode re-pulses the synthesizer reset after every sweep.
    markBase();
    writeCfg(CFG0, 5);
    writeCfg(CFG1, EN | CONT | 2);
    waitDone(1000, n);
    waitCycles(1);
    checkOutput("cont_rst_after_done1", int'(freq_step_reset_out), 1);
    waitDone(1000, n);
    checkOutput("cont_done2_cycle", n, modelDone(5, 2) - 1);
    waitCycles(1);
    checkOutput("cont_rst_after_done2", int'(freq_step_reset_out), 1);
    waitCycles(2);
    checkOutput("cont_rst_rises", rst_rises - rst_base, 3);
    waitSig(0, 1'b1, 500, "cont_record");
    idx = int'(step_index);
    done_snap = done_cnt;
    writeCfg(CFG1, CONT | 2);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_rx_record", int'(rx_record), 0);
    checkOutput("abort_step_index_held", int'(step_index), idx);
    waitCycles(5);
    checkOutput("abort_no_done", done_cnt - done_snap, 0);
    checkOutput("abort_stays_idle", int'(busy), 0);

    // A mid-sweep CFG0 write only affects the following sweep.
    markBase();
    writeCfg(CFG0, 20);
    writeCfg(CFG1, EN | 2);
    waitSig(0, 1'b1, 500, "cfg_mid_record");
    writeCfg(CFG0, 7);
    waitDone(1000, n);
    checkSweep("cfg_mid", n, -1, 20, 2, 1);
    waitCycles(2);
    markBase();
    writeCfg(CFG1, EN | 2);
    waitDone(1000, n);
    checkSweep("cfg_next", n, modelDone(7, 2), 7, 2, 1);

    // Asynchronous reset during a step pulse, then default window length.
    writeCfg(CFG0, 5);
    writeCfg(CFG1, EN | 3);
    waitSig(1, 1'b1, 1000, "ar_step");
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_step_out", int'(freq_step_out), 0);
    checkOutput("ar_busy", int'(busy), 0);
    checkOutput("ar_step_index", int'(step_index), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    waitCycles(3);
    checkOutput("ar_idle", int'(busy), 0);
    markBase();
    writeCfg(CFG1, EN | 0);
    waitDone(20000, n);
    checkSweep("default_cfg", n, modelDone(15000, 1), 15000, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fast_square_sweep_ctrl.md
# fast_square_sweep_ctrl

Parametrised successor to the fast-square sweep controller. Drives the synthesizer frequency-step/step-reset lines and the per-step RX record window (`rx_reset`, `rx_next`, `rx_record`) for `fast_square_rx`. Adds run-time step count and record length via the serial settings bus, single-shot or continuous sweep, PLL-lock timeout with skip, and sticky status flags. Sits in the RX section of `usrp_std`, clocked by `clk64`, with `pll_locked` taken from a daughterboard I/O pin.

## Interface
- `FR_BASE`, 64: serial address of CFG0; CFG1 is `FR_BASE+1`.
- `CNT_W`, 16: width of the record/settle/timeout counters.
- `STEP_W`, 8: width of the step count and step index.
- `SETTLE_TICKS`, 64: cycles waited after lock before recording.
- `LOCK_TIMEOUT`, 4096: maximum cycles waited for lock per step.
- `PULSE_TICKS`, 4: width in cycles of the step and step-reset pulses.
- `clock`  in  1  system clock (`clk64`).
- `reset_n`  in  1  asynchronous, active-low reset.
- `serial_strobe`  in  1  settings-bus write strobe.
- `serial_addr`  in  7  settings-bus address.
- `serial_data`  in  32  settings-bus data.
- `pll_locked`  in  1  asynchronous PLL lock indicator.
- `freq_step_reset_out`  out  1  synthesizer return-to-start pulse.
- `freq_step_out`  out  1  synthesizer advance-one-step pulse.
- `rx_reset`  out  1  fast_square_rx reset, high during sweep start.
- `rx_next`  out  1  one-cycle pulse: advance RX accumulator to the next step.
- `rx_record`  out  1  high while the RX accumulator integrates.
- `step_index`  out  STEP_W  current step, 0-based.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `sweep_done`  out  1  one-cycle pulse at the end of each sweep.
- `lock_fail`  out  1  sticky: a step timed out waiting for lock.
- `lock_drop`  out  1  sticky: lock was lost during a record window.

## Operation
- CFG0 write: `record_ticks` = data[CNT_W-1:0].
- CFG1 write: `num_steps` = data[STEP_W-1:0]; `continuous` = data[16]; `enable` = data[17]; data[18]=1 clears both sticky flags.
- Writes to any other address are ignored.
- Reset values: record_ticks=15000, num_steps=1, enable=0, continuous=0.
- `pll_locked` passes through a 2-flop synchronizer. All internal use takes the synchronized value.
- At sweep start (START entry), `record_ticks` and `num_steps` are copied to shadow registers. Config writes mid-sweep take effect at the next sweep. A zero in either is used as 1.
- FSM states:
  - IDLE: go to START when enable=1.
  - START: `rx_reset`=1 and `freq_step_reset_out`=1 for PULSE_TICKS cycles; step_index←0; then WAIT_LOCK.
  - WAIT_LOCK: when synced lock=1, go to SETTLE. If the counter reaches LOCK_TIMEOUT, set `lock_fail` and go to ADVANCE (record skipped).
  - SETTLE: SETTLE_TICKS cycles. If lock is lost here, return to WAIT_LOCK with the timeout counter restarted.
  - RECORD: `rx_record`=1 for exactly shadow record_ticks cycles. A lock loss sets `lock_drop`; recording continues.
  - ADVANCE: `rx_next` pulses for 1 cycle.
    - If step_index = shadow num_steps−1: pulse `sweep_done`, then go to START if continuous, else clear enable and go to IDLE.
    - Otherwise: increment step_index and go to STEP.
  - STEP: `freq_step_out`=1 for PULSE_TICKS cycles, then WAIT_LOCK.
- enable cleared by a write mid-sweep: the next cycle is IDLE; all pulse/record outputs low; step_index holds its value; no `sweep_done`.
- A CFG1 clear-flag write in the same cycle as a flag-set event: the set wins.
- Reset: all outputs 0, FSM in IDLE, config at reset values, synchronizer cleared.

## Timing
- All outputs are registered.
- Config write is visible one cycle after `serial_strobe`. IDLE→START occurs on the cycle after enable becomes 1.
- Lock-to-FSM latency is 2 cycles (synchronizer), plus 1 cycle for the state register.
- Per locked step, minimum length = PULSE_TICKS + 3 + SETTLE_TICKS + record_ticks + 1 cycles.
- `rx_record` falls on the same edge on which `rx_next` rises. `rx_next` and `sweep_done` are coincident on the last step.
- Counters never wrap: comparisons are terminal-count equality, and counters clear on state entry.

## Test plan
- Reset, then CFG0=100 and CFG1={enable,num_steps=3}, with pll_locked tied 1:
  - 3 record windows of exactly 100 cycles each.
  - 2 `freq_step_out` pulses of 4 cycles.
  - step_index goes 0,1,2.
  - One `sweep_done`, then busy=0.
- pll_locked held 0 on step 1 of 3: `lock_fail` set after 4096 cycles; no record on step 1; `rx_next` still pulses; sweep completes.
- Lock dropped for 10 cycles mid-RECORD: `lock_drop`=1; window still 100 cycles. Then a CFG1 write with bit18=1 clears both flags.
- Continuous mode with num_steps=2: `freq_step_reset_out` re-pulses after each `sweep_done`. Clearing enable mid-RECORD: busy=0 and rx_record=0 the next cycle.
- CFG0=0 and num_steps=0: exactly one 1-cycle record window, then done. A CFG0 write mid-sweep changes only the next sweep's window length.
- Assert reset_n low mid-STEP: all outputs 0 immediately (asynchronously); config returns to defaults.
